// File: rtl/accm_dump_pkg.sv
// Shared mode constants and FSM state encoding for the integrate-and-dump accumulator.
// Latency: none (declarations only).
// Backpressure: none.
package accm_dump_pkg;

  // Arithmetic mode select
  localparam logic ACCM_WRAP = 1'b0;
  localparam logic ACCM_SAT  = 1'b1;

  // Block FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DUMP = 2'd2
  } state_t;

endpackage

// File: rtl/accm_dump_if.sv
// Sample-side controls and accumulator/dump results of accm_dump.
// Latency: none (wiring only).
// Backpressure: none; the consumer must take DUMP while DUMP_VLD is high.
interface accm_dump_if #(
  parameter int XW = 7,
  parameter int AW = 16,
  parameter int CW = 4
);
  logic          en;
  logic [XW-1:0] X;
  logic          clr;
  logic          flush;
  logic          mode;
  logic [AW-1:0] ACC;
  logic          CO;
  logic          Mx;
  logic [CW-1:0] cnt;
  logic [AW-1:0] DUMP;
  logic          DUMP_OVF;
  logic          DUMP_VLD;

  modport master (
    output en, X, clr, flush, mode,
    input  ACC, CO, Mx, cnt, DUMP, DUMP_OVF, DUMP_VLD
  );

  modport slave (
    input  en, X, clr, flush, mode,
    output ACC, CO, Mx, cnt, DUMP, DUMP_OVF, DUMP_VLD
  );
endinterface

// File: rtl/accm_dump_add_ws.sv
// Adds a zero-extended sample to the accumulator with wrap or saturate result.
// Latency: combinational.
// Backpressure: none.
module accm_dump_add_ws
  import accm_dump_pkg::*;
#(
  parameter int XW = 7,
  parameter int AW = 16
) (
  input  logic [AW-1:0] i_acc,
  input  logic [XW-1:0] i_x,
  input  logic          i_mode,
  output logic [AW-1:0] o_next,
  output logic          o_ovf
);

  // One extra bit catches the carry out of the AW-bit sum
  logic [AW:0] w_sum;

  assign w_sum  = {1'b0, i_acc} + {{(AW + 1 - XW){1'b0}}, i_x};
  assign o_ovf  = w_sum[AW];
  // Saturate pins the result at full scale; wrap simply drops the carry
  assign o_next = (o_ovf && (i_mode == ACCM_SAT)) ? {AW{1'b1}} : w_sum[AW-1:0];

endmodule

// File: rtl/accm_dump.sv
// Integrate-and-dump: sums NSMP accepted samples (or up to a flush) and emits the block sum.
// Latency: every output registered; a sample taken at edge k is visible after edge k.
// Backpressure: none; DUMP_VLD is a 1-cycle strobe and DUMP holds until the next dump.
module accm_dump
  import accm_dump_pkg::*;
#(
  parameter int XW   = 7,
  parameter int AW   = 16,
  parameter int NSMP = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  accm_dump_if.slave bus
);

  localparam int            CW   = $clog2(NSMP);
  localparam logic [CW-1:0] LAST = CW'(NSMP - 1);

  state_t        r_state, w_state_nx;
  logic [AW-1:0] r_acc, w_acc_nx;
  logic [AW-1:0] r_dump, w_dump_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic          r_co, w_co_nx;
  logic          r_mx, w_mx_nx;
  logic          r_dovf, w_dovf_nx;
  logic          r_dvld, w_dvld_nx;

  logic [AW-1:0] w_add;
  logic          w_ovf;
  logic          w_term;
  logic          w_flush;
  logic          w_dump;

  accm_dump_add_ws #(
    .XW (XW),
    .AW (AW)
  ) u_add (
    .i_acc  (r_acc),
    .i_x    (bus.X),
    .i_mode (bus.mode),
    .o_next (w_add),
    .o_ovf  (w_ovf)
  );

  // Terminal count and an in-block flush merge into a single dump event;
  // flush outside RUN has no partial block to report and is ignored.
  assign w_term  = bus.en && (r_cnt == LAST);
  assign w_flush = bus.flush && (r_state == ST_RUN);
  assign w_dump  = w_term || w_flush;

  // Next-state and next-register values; clr outranks dump, dump outranks accumulate
  always_comb begin
    w_state_nx = r_state;
    w_acc_nx   = r_acc;
    w_cnt_nx   = r_cnt;
    w_mx_nx    = r_mx;
    w_co_nx    = 1'b0;
    w_dump_nx  = r_dump;
    w_dovf_nx  = r_dovf;
    w_dvld_nx  = 1'b0;
    if (bus.clr) begin
      w_state_nx = ST_IDLE;
      w_acc_nx   = '0;
      w_cnt_nx   = '0;
      w_mx_nx    = 1'b0;
    end else begin
      w_co_nx = bus.en && w_ovf && (bus.mode == ACCM_WRAP);
      if (w_dump) begin
        // Include this edge's sample in the closing block when one is offered
        w_dump_nx  = bus.en ? w_add : r_acc;
        w_dovf_nx  = r_mx | (bus.en & w_ovf);
        w_acc_nx   = '0;
        w_cnt_nx   = '0;
        w_mx_nx    = 1'b0;
        w_dvld_nx  = 1'b1;
        w_state_nx = ST_DUMP;
      end else if (bus.en) begin
        w_acc_nx   = w_add;
        w_cnt_nx   = r_cnt + CW'(1);
        w_mx_nx    = r_mx | w_ovf;
        w_state_nx = ST_RUN;
      end else if (r_state == ST_DUMP) begin
        w_state_nx = ST_IDLE;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Accumulator, counter and dump output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_mx   <= 1'b0;
      r_co   <= 1'b0;
      r_dump <= '0;
      r_dovf <= 1'b0;
      r_dvld <= 1'b0;
    end else begin
      r_acc  <= w_acc_nx;
      r_cnt  <= w_cnt_nx;
      r_mx   <= w_mx_nx;
      r_co   <= w_co_nx;
      r_dump <= w_dump_nx;
      r_dovf <= w_dovf_nx;
      r_dvld <= w_dvld_nx;
    end
  end

  assign bus.ACC      = r_acc;
  assign bus.CO       = r_co;
  assign bus.Mx       = r_mx;
  assign bus.cnt      = r_cnt;
  assign bus.DUMP     = r_dump;
  assign bus.DUMP_OVF = r_dovf;
  assign bus.DUMP_VLD = r_dvld;

endmodule

// File: tb/tb_accm_dump.sv
// Directed bench for accm_dump: three instances (NSMP = 4, 16, 1024) on one clock/reset.
// Inputs change 1ns after the rising edge; outputs are checked 1ns after the rising edge.
// Expected values are hand-computed constants.
module tb_accm_dump;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  accm_dump_if #(.XW(7), .AW(16), .CW(2))  b4  ();
  accm_dump_if #(.XW(7), .AW(16), .CW(4))  b16 ();
  accm_dump_if #(.XW(7), .AW(16), .CW(10)) b1k ();

  accm_dump #(.XW(7), .AW(16), .NSMP(4)) u4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4)
  );

  accm_dump #(.XW(7), .AW(16), .NSMP(16)) u16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b16)
  );

  accm_dump #(.XW(7), .AW(16), .NSMP(1024)) u1k (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1k)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full 1024-sample block of X=100 on the NSMP=1024 instance in the given mode
  task automatic run_1k(input logic md, input int exp_co);
    int co_n;
    co_n     = 0;
    b1k.mode = md;
    b1k.X    = 7'd100;
    b1k.en   = 1'b1;
    for (int i = 1; i <= 1024; i++) begin
      tick(1);
      if (b1k.CO) co_n++;
      if (i == 655) begin
        chk("1k acc@655", 32'(b1k.ACC), 65500);
        chk("1k cnt@655", 32'(b1k.cnt), 655);
        chk("1k mx@655", 32'(b1k.Mx), 0);
      end
      if (i == 656) begin
        chk("1k acc@656", 32'(b1k.ACC), md ? 65535 : 64);
        chk("1k co@656", 32'(b1k.CO), md ? 0 : 1);
        chk("1k mx@656", 32'(b1k.Mx), 1);
      end
      if (i == 657) chk("1k co@657", 32'(b1k.CO), 0);
      if (i == 700) chk("1k acc@700", 32'(b1k.ACC), md ? 65535 : 4464);
      if (i == 1023) chk("1k vld@1023", 32'(b1k.DUMP_VLD), 0);
      if (i == 1024) begin
        chk("1k vld@1024", 32'(b1k.DUMP_VLD), 1);
        chk("1k dump", 32'(b1k.DUMP), md ? 65535 : 36864);
        chk("1k dump_ovf", 32'(b1k.DUMP_OVF), 1);
        chk("1k acc restart", 32'(b1k.ACC), 0);
        chk("1k mx restart", 32'(b1k.Mx), 0);
      end
    end
    b1k.en = 1'b0;
    tick(1);
    chk("1k co pulses", 32'(co_n), 32'(exp_co));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b1;
    b4.en  = 1'b0; b4.X  = '0; b4.clr  = 1'b0; b4.flush  = 1'b0; b4.mode  = 1'b0;
    b16.en = 1'b0; b16.X = '0; b16.clr = 1'b0; b16.flush = 1'b0; b16.mode = 1'b0;
    b1k.en = 1'b0; b1k.X = '0; b1k.clr = 1'b0; b1k.flush = 1'b0; b1k.mode = 1'b0;

    // Reset state, checked before any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("rst acc", 32'(b4.ACC), 0);
    chk("rst cnt", 32'(b4.cnt), 0);
    chk("rst dump", 32'(b4.DUMP), 0);
    chk("rst vld", 32'(b4.DUMP_VLD), 0);
    tick(2);
    rst_n = 1'b1;

    // NSMP=4, X=100 continuous: back-to-back dumps of 400
    b4.X  = 7'd100;
    b4.en = 1'b1;
    tick(3);
    chk("n4 acc@3", 32'(b4.ACC), 300);
    chk("n4 vld@3", 32'(b4.DUMP_VLD), 0);
    tick(1);
    chk("n4 vld@4", 32'(b4.DUMP_VLD), 1);
    chk("n4 dump@4", 32'(b4.DUMP), 400);
    chk("n4 ovf@4", 32'(b4.DUMP_OVF), 0);
    chk("n4 acc@4", 32'(b4.ACC), 0);
    chk("n4 cnt@4", 32'(b4.cnt), 0);
    tick(1);
    chk("n4 vld@5", 32'(b4.DUMP_VLD), 0);
    chk("n4 acc@5", 32'(b4.ACC), 100);
    tick(3);
    chk("n4 vld@8", 32'(b4.DUMP_VLD), 1);
    chk("n4 dump@8", 32'(b4.DUMP), 400);
    b4.en = 1'b0;
    tick(1);
    chk("n4 idle acc", 32'(b4.ACC), 0);

    // clr on the terminal-count edge wins: no dump, DUMP keeps 400
    b4.X  = 7'd5;
    b4.en = 1'b1;
    tick(3);
    chk("clr pre acc", 32'(b4.ACC), 15);
    b4.clr = 1'b1;
    tick(1);
    chk("clr vld", 32'(b4.DUMP_VLD), 0);
    chk("clr dump", 32'(b4.DUMP), 400);
    chk("clr acc", 32'(b4.ACC), 0);
    chk("clr cnt", 32'(b4.cnt), 0);
    b4.clr = 1'b0;
    b4.en  = 1'b0;
    tick(1);

    // en gaps: four samples of 9 spread over seven edges
    b4.X = 7'd9;
    for (int i = 0; i < 7; i++) begin
      b4.en = (i % 2 == 0);
      tick(1);
      if (i == 1) begin
        chk("gap hold acc", 32'(b4.ACC), 9);
        chk("gap hold cnt", 32'(b4.cnt), 1);
      end
      if (i < 6) chk("gap vld", 32'(b4.DUMP_VLD), 0);
    end
    chk("gap vld end", 32'(b4.DUMP_VLD), 1);
    chk("gap dump", 32'(b4.DUMP), 36);
    b4.en = 1'b0;
    tick(1);

    // NSMP=16: five samples of 7 then an early flush
    b16.X  = 7'd7;
    b16.en = 1'b1;
    tick(5);
    chk("fl pre acc", 32'(b16.ACC), 35);
    chk("fl pre cnt", 32'(b16.cnt), 5);
    b16.en    = 1'b0;
    b16.flush = 1'b1;
    tick(1);
    chk("fl vld", 32'(b16.DUMP_VLD), 1);
    chk("fl dump", 32'(b16.DUMP), 35);
    chk("fl cnt", 32'(b16.cnt), 0);
    chk("fl acc", 32'(b16.ACC), 0);
    tick(1);
    chk("fl dumpst vld", 32'(b16.DUMP_VLD), 0);
    tick(1);
    chk("fl idle vld", 32'(b16.DUMP_VLD), 0);
    chk("fl idle dump", 32'(b16.DUMP), 35);
    b16.flush = 1'b0;

    // Asynchronous reset mid-block, mid-cycle
    b16.en = 1'b1;
    tick(3);
    chk("ar pre acc", 32'(b16.ACC), 21);
    b16.en = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("ar acc", 32'(b16.ACC), 0);
    chk("ar cnt", 32'(b16.cnt), 0);
    chk("ar dump16", 32'(b16.DUMP), 0);
    chk("ar dump4", 32'(b4.DUMP), 0);
    chk("ar vld4", 32'(b4.DUMP_VLD), 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("ar post vld", 32'(b16.DUMP_VLD), 0);
    chk("ar post acc", 32'(b16.ACC), 0);

    // NSMP=1024, X=100: wrap mode, then saturate mode
    run_1k(1'b0, 1);
    run_1k(1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
